// File: rtl/divider_seq_pkg.sv
// divider_seq_pkg: shared definitions for the sequential restoring divider.
// FSM state encoding, default operand widths and the bit-counter width helper.
package divider_seq_pkg;

  localparam int DVD_W_DEF = 8;
  localparam int DVS_W_DEF = 4;
  localparam int CNT_W_DEF = $clog2(DVD_W_DEF);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

  // Width of a counter that must hold DVD_W-1 (at least one bit).
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/divider_step.sv
// divider_step: one combinational restoring-division step.
// Shifts the next dividend bit into the partial remainder and subtracts the
// divisor when it fits, producing one quotient bit.
module divider_step
  import divider_seq_pkg::*;
#(
  parameter int DVS_W = DVS_W_DEF
) (
  input  logic [DVS_W-1:0] pr_in,
  input  logic             dvd_bit,
  input  logic [DVS_W-1:0] divisor,
  output logic [DVS_W-1:0] pr_out,
  output logic             q_bit
);

  logic [DVS_W:0] trial;

  // Trial subtraction; the difference always fits DVS_W bits because the
  // incoming remainder is below the divisor, so a narrow subtract suffices.
  always_comb begin
    trial  = {pr_in, dvd_bit};
    q_bit  = (trial >= {1'b0, divisor});
    pr_out = q_bit ? (trial[DVS_W-1:0] - divisor) : trial[DVS_W-1:0];
  end

endmodule

// File: rtl/divider_seq.sv
// divider_seq: iterative restoring unsigned divider, one quotient bit per clock.
// Start/busy/done handshake; results held until the next accepted start.
// Optional macro DIVIDER_DBZ_CHECK_EN: a zero divisor skips the RUN phase and
// raises dbz with the DONE pulse; when undefined dbz is tied low.
module divider_seq
  import divider_seq_pkg::*;
#(
  parameter int DVD_W = DVD_W_DEF,
  parameter int DVS_W = DVS_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             dbz
);

  localparam int CNT_W = cnt_width(DVD_W);

  div_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [DVD_W-1:0] dvd_reg;
  logic [DVS_W-1:0] dvs_reg;
  logic [DVS_W-1:0] pr_reg;
  logic [DVD_W-1:0] q_reg;
  logic [DVD_W-1:0] quotient_reg;
  logic [DVS_W-1:0] remainder_reg;

  logic             accept;
  logic             dbz_hit;
  logic [DVS_W-1:0] pr_step;
  logic             q_bit;
  logic [DVD_W-1:0] q_shift;

  assign accept  = start && (state_reg != ST_RUN);
  assign q_shift = {q_reg[DVD_W-2:0], q_bit};

`ifdef DIVIDER_DBZ_CHECK_EN
  logic dbz_reg;
  assign dbz_hit = (divisor == '0);
  assign dbz     = dbz_reg;
`else
  assign dbz_hit = 1'b0;
  assign dbz     = 1'b0;
`endif

  divider_step #(.DVS_W(DVS_W)) u_step (
    .pr_in   (pr_reg),
    .dvd_bit (dvd_reg[DVD_W-1]),
    .divisor (dvs_reg),
    .pr_out  (pr_step),
    .q_bit   (q_bit)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic: a zero divisor with the check enabled jumps straight to DONE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start) state_next = dbz_hit ? ST_DONE : ST_RUN;
        else       state_next = ST_IDLE;
      end
      ST_RUN:  if (cnt_reg == '0) state_next = ST_DONE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath: latch operands on accept, shift one bit per RUN cycle, and
  // publish the result only on the final step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg       <= '0;
      dvd_reg       <= '0;
      dvs_reg       <= '0;
      pr_reg        <= '0;
      q_reg         <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
`ifdef DIVIDER_DBZ_CHECK_EN
      dbz_reg       <= 1'b0;
`endif
    end else if (accept) begin
      cnt_reg <= CNT_W'(DVD_W - 1);
      dvd_reg <= dividend;
      dvs_reg <= divisor;
      pr_reg  <= '0;
      q_reg   <= '0;
`ifdef DIVIDER_DBZ_CHECK_EN
      dbz_reg <= dbz_hit;
      if (dbz_hit) begin
        quotient_reg  <= '1;
        remainder_reg <= dividend[DVS_W-1:0];
      end
`endif
    end else if (state_reg == ST_RUN) begin
      cnt_reg <= cnt_reg - 1'b1;
      dvd_reg <= {dvd_reg[DVD_W-2:0], 1'b0};
      pr_reg  <= pr_step;
      q_reg   <= q_shift;
      if (cnt_reg == '0) begin
        quotient_reg  <= q_shift;
        remainder_reg <= pr_step;
      end
    end
  end

  assign busy      = (state_reg == ST_RUN);
  assign done      = (state_reg == ST_DONE);
  assign quotient  = quotient_reg;
  assign remainder = remainder_reg;

endmodule

// File: tb/tb_divider_seq.sv
// tb_divider_seq: self-checking bench for divider_seq (8-bit / 4-bit default).
// Directed table, hand-written handshake/reset sequences, exhaustive and random
// sweeps checked against plain-arithmetic division.
module tb_divider_seq;

`ifdef DIVIDER_DBZ_CHECK_EN
  localparam bit DBZ_EN = 1'b1;
`else
  localparam bit DBZ_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic       busy, done, dbz;
  logic [7:0] quotient;
  logic [3:0] remainder;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  divider_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz)
  );

  typedef struct {
    logic [7:0] a;
    logic [3:0] d;
    logic [7:0] q;
    logic [3:0] r;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Reference: plain integer division; zero divisor gives all-ones quotient
  // and the low dividend bits as remainder.
  function automatic void ref_div(input logic [7:0] a, input logic [3:0] d,
                                  output logic [7:0] q, output logic [3:0] r,
                                  output logic z, output int lat);
    if (d == 0) begin
      q   = 8'hFF;
      r   = a[3:0];
      z   = DBZ_EN;
      lat = DBZ_EN ? 1 : 9;
    end else begin
      q   = a / {4'd0, d};
      r   = 4'(a % {4'd0, d});
      z   = 1'b0;
      lat = 9;
    end
  endfunction

  // Waits (bounded) for done; lat counts cycles after the start cycle.
  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Issue one operation from an idle/done state and collect its result.
  task automatic run_op(input logic [7:0] a, input logic [3:0] d,
                        output logic [7:0] q, output logic [3:0] r,
                        output logic z, output int lat);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = d;
    @(negedge clk);
    start = 1'b0; dividend = 8'($urandom); divisor = 4'($urandom);
    wait_done(1, lat);
    q = quotient; r = remainder; z = dbz;
  endtask

  initial begin
    vec_t       tbl[8];
    logic [7:0] q, eq;
    logic [3:0] r, er;
    logic       z, ez;
    int         lat, elat, lat2, ndone;
    logic [7:0] ra;
    logic [3:0] rd;
    bit         ok;

    tbl[0] = '{8'd200, 4'd7,  8'd28,  4'd4};
    tbl[1] = '{8'd255, 4'd15, 8'd17,  4'd0};
    tbl[2] = '{8'd5,   4'd9,  8'd0,   4'd5};
    tbl[3] = '{8'd255, 4'd1,  8'd255, 4'd0};
    tbl[4] = '{8'hA5,  4'd0,  8'd255, 4'd5};
    tbl[5] = '{8'd100, 4'd3,  8'd33,  4'd1};
    tbl[6] = '{8'd0,   4'd5,  8'd0,   4'd0};
    tbl[7] = '{8'd15,  4'd15, 8'd1,   4'd0};

    // Reset then idle.
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset quotient", int'(quotient), 0);
    check("reset remainder", int'(remainder), 0);
    check("reset dbz", int'(dbz), 0);

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].a, tbl[i].d, q, r, z, lat);
      $display("op %0d/%0d -> q=%0d r=%0d dbz=%0d lat=%0d", tbl[i].a, tbl[i].d, q, r, z, lat);
      check($sformatf("tbl%0d quotient", i), int'(q), int'(tbl[i].q));
      check($sformatf("tbl%0d remainder", i), int'(r), int'(tbl[i].r));
      check($sformatf("tbl%0d dbz", i), int'(z), (tbl[i].d == 0) ? int'(DBZ_EN) : 0);
      check($sformatf("tbl%0d latency", i), lat, (tbl[i].d == 0 && DBZ_EN) ? 1 : 9);
      @(negedge clk);
      check($sformatf("tbl%0d done pulse width", i), int'(done), 0);
    end

    // start pulsed mid-RUN with other operands must be ignored.
    @(negedge clk);
    start = 1'b1; dividend = 8'd200; divisor = 4'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("midrun busy", int'(busy), 1);
    start = 1'b1; dividend = 8'd17; divisor = 4'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done(4, lat);
    check("midrun latency", lat, 9);
    check("midrun quotient", int'(quotient), 28);
    check("midrun remainder", int'(remainder), 4);
    @(negedge clk);
    repeat (12) @(negedge clk);
    check("midrun no extra done", int'(done), 0);

    // Reset asserted at RUN cycle 4 aborts at once with no done pulse.
    @(negedge clk);
    start = 1'b1; dividend = 8'd77; divisor = 4'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort busy", int'(busy), 0);
    check("abort done", int'(done), 0);
    check("abort quotient", int'(quotient), 0);
    check("abort remainder", int'(remainder), 0);
    @(negedge clk); rst = 1'b0;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check("abort no done", ndone, 0);
    run_op(8'd100, 4'd3, q, r, z, lat);
    check("post-abort quotient", int'(q), 33);
    check("post-abort remainder", int'(r), 1);
    check("post-abort latency", lat, 9);

    // Back-to-back: start held in DONE restarts with a 9-cycle period.
    run_op(8'd123, 4'd10, q, r, z, lat);
    start = 1'b1; dividend = 8'd250; divisor = 4'd11;
    @(negedge clk);
    start = 1'b0;
    wait_done(1, lat2);
    check("b2b first quotient", int'(q), 12);
    check("b2b first remainder", int'(r), 3);
    check("b2b period", lat2, 9);
    check("b2b second quotient", int'(quotient), 22);
    check("b2b second remainder", int'(remainder), 8);

    // Exhaustive sweep followed by random operands, both against the model.
    for (int k = 0; k < 4096 + 200; k++) begin
      if (k < 4096) begin
        ra = 8'(k >> 4);
        rd = 4'(k);
      end else begin
        ra = 8'($urandom);
        rd = 4'($urandom_range(0, 15));
      end
      run_op(ra, rd, q, r, z, lat);
      ref_div(ra, rd, eq, er, ez, elat);
      ok = (q == eq) && (r == er) && (z == ez) && (lat == elat);
      if (rd != 0)
        ok = ok && (int'(q) * int'(rd) + int'(r) == int'(ra)) && (r < rd);
      n_tests++;
      if (!ok) begin
        n_fail++;
        $display("FAIL sweep %0d/%0d: got q=%0d r=%0d dbz=%0d lat=%0d expected q=%0d r=%0d dbz=%0d lat=%0d",
                 ra, rd, q, r, z, lat, eq, er, ez, elat);
      end
    end
    $display("sweep done: %0d operations", 4096 + 200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
